// File: rtl/ei_reg_responder.sv
// ei_reg_responder: responder end of the EI register protocol.
// Decodes command bytes from the UART receiver, reads or writes the EI
// register bank, and returns read data, ACK or NAK bytes to the UART
// transmitter. The whole bank is exported flat for the BLE setup logic.
module ei_reg_responder #(
    parameter int          NUM_REGS       = 41,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  BAUD_DEFAULT   = 8'h04,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_valid_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic [NUM_REGS*8-1:0]   regs_o,
    output logic                    wr_strobe_o,
    output logic [5:0]              wr_addr_o
);

    // Fixed register indices in the ei_regs_t map
    localparam int BAUD_IDX = 27;
    localparam int ERR_IDX  = 40;

    // Error register bit positions
    localparam int ERR_BAD_INDEX = 0;
    localparam int ERR_TIMEOUT   = 1;
    localparam int ERR_RSVD_BIT  = 2;
    localparam int ERR_OVERRUN   = 3;

    localparam int                CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]        NUM_REGS_L = 7'(NUM_REGS);
    localparam logic [5:0]        ERR_IDX_L  = 6'(ERR_IDX);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_RESP      = 2'd2
    } state_t;

    // Bank contents after reset: everything zero except the baud rate
    function automatic logic [NUM_REGS-1:0][7:0] bank_reset_val();
        logic [NUM_REGS-1:0][7:0] v;
        v           = '0;
        v[BAUD_IDX] = BAUD_DEFAULT;
        return v;
    endfunction

    state_t                    state_q, state_d;
    logic [NUM_REGS-1:0][7:0]  bank_q, bank_d;
    logic [5:0]                idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      wr_strobe_q, wr_strobe_d;
    logic [5:0]                wr_addr_q, wr_addr_d;
    logic                      rd_err_q, rd_err_d;   // pending response is a read of the error register
    logic [7:0]                err_set_s;
    logic                      err_clr_s;

    // Next-state, bank update and response generation
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_err_d    = rd_err_q;
        err_set_s   = 8'h00;
        err_clr_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i[6]) begin
                        err_set_s[ERR_RSVD_BIT] = 1'b1;
                        tx_data_d  = NAK_BYTE;
                        tx_valid_d = 1'b1;
                        rd_err_d   = 1'b0;
                        state_d    = ST_RESP;
                    end else if ({1'b0, rx_data_i[5:0]} >= NUM_REGS_L) begin
                        // Bad index NAKs at once, even for a write command
                        err_set_s[ERR_BAD_INDEX] = 1'b1;
                        tx_data_d  = NAK_BYTE;
                        tx_valid_d = 1'b1;
                        rd_err_d   = 1'b0;
                        state_d    = ST_RESP;
                    end else if (rx_data_i[7]) begin
                        idx_d   = rx_data_i[5:0];
                        cnt_d   = '0;
                        state_d = ST_WAIT_DATA;
                    end else begin
                        tx_data_d  = bank_q[rx_data_i[5:0]];
                        tx_valid_d = 1'b1;
                        rd_err_d   = (rx_data_i[5:0] == ERR_IDX_L);
                        state_d    = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_DATA: begin
                // A data byte on the terminal count cycle still completes the write
                if (rx_valid_i) begin
                    if (idx_q != ERR_IDX_L) begin
                        bank_d[idx_q] = rx_data_i;
                    end else begin
                        bank_d = bank_q;
                    end
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = idx_q;
                    tx_data_d   = ACK_BYTE;
                    tx_valid_d  = 1'b1;
                    rd_err_d    = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_set_s[ERR_TIMEOUT] = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rx_valid_i) begin
                    err_set_s[ERR_OVERRUN] = 1'b1;
                end else begin
                    err_set_s[ERR_OVERRUN] = 1'b0;
                end
                if (tx_valid_q && tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    err_clr_s  = rd_err_q;
                    rd_err_d   = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end

            default: begin
                tx_valid_d = 1'b0;
                rd_err_d   = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // Error register: cleared by the handshake of its own read, but a
        // same-cycle event keeps its bit; bus writes never land here
        bank_d[ERR_IDX] = (err_clr_s ? 8'h00 : bank_q[ERR_IDX]) | err_set_s;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_q      <= bank_reset_val();
            idx_q       <= 6'd0;
            cnt_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 6'd0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign regs_o      = bank_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;

endmodule

// File: doc/ei_reg_responder.md
Name: ei_reg_responder

Overview:
- Responder end of the external-interface (EI) register protocol.
- Consumes a command byte stream from the UART receiver and maintains the EI register bank, indexed by the ei_regs_t enum values (EIR_TEST=0 … EIR_ERROR=40).
- Returns ACK or read-data bytes to the UART transmitter.
- Exports the whole bank to the BLE setup logic as a flat bus.

Parameters:
- NUM_REGS, 41, number of EI registers (ei_regs_t entries 0..40).
- TIMEOUT_CYCLES, 100000, maximum cycles allowed between a write command byte and its data byte.
- BAUD_DEFAULT, 8'h04, reset value of EIR_BAUD_RATE (index 27).
- ACK_BYTE, 8'hAA, response to a completed write.
- NAK_BYTE, 8'hEE, response to an invalid command.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  response valid; held until accepted
- tx_ready_i  in  1  transmitter accepts byte when tx_valid_o & tx_ready_i
- regs_o  out  NUM_REGS*8  register bank, reg k at [8k+7:8k]
- wr_strobe_o  out  1  one-cycle pulse on each bank write
- wr_addr_o  out  6  index of the last written register

Behaviour:
- Reset values (async, rst_n low):
  - All registers 0, except EIR_BAUD_RATE = BAUD_DEFAULT.
  - tx_valid_o=0, tx_data_o=0, wr_strobe_o=0, wr_addr_o=0.
  - FSM in IDLE; timeout counter 0.
- Command byte format:
  - bit7 = 1 for write, 0 for read.
  - bit6 reserved, must be 0.
  - bits5:0 = register index.
- FSM states: IDLE, WAIT_DATA, RESP.
- IDLE, on rx_valid_i:
  - bit6=1: set ERROR bit2, load NAK, go to RESP.
  - Index ≥ NUM_REGS: set ERROR bit0, load NAK, go to RESP. A write command with a bad index also NAKs immediately and does not wait for a data byte.
  - Valid read: load reg[index] into tx_data_o, go to RESP.
  - Valid write: latch the index, clear the counter, go to WAIT_DATA.
- WAIT_DATA:
  - On rx_valid_i, the cycle after:
    - reg[index] ← rx_data_i, visible on regs_o;
    - wr_strobe_o pulses;
    - wr_addr_o = index;
    - tx_data_o = ACK_BYTE, tx_valid_o=1;
    - go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no byte: set ERROR bit1, return to IDLE, send no response.
  - A byte arriving on that terminal cycle wins: the write completes normally.
- RESP:
  - tx_valid_o=1 and tx_data_o held stable until tx_valid_o & tx_ready_i.
  - Go to IDLE the next cycle.
  - rx_valid_i while in RESP: byte dropped, ERROR bit3 (overrun) set.
- Latency:
  - Read or NAK: tx_valid_o asserts 1 cycle after the accepted command byte.
  - Write: register update and ACK occur 1 cycle after the data byte.
- EIR_ERROR (index 40):
  - Bus writes are ignored, but ACK is still returned and wr_strobe_o still pulses.
  - A read returns the snapshot value. The register clears on the tx handshake of that read.
  - An error event in the same cycle as the clear leaves its bit set.
- Reset asserted mid-transaction aborts everything: no response is emitted after release.

Test Plan:
- Reset then read cmd 8'h1B (EIR_BAUD_RATE) with tx_ready_i=1 -> tx_data_o=8'h04, tx_valid_o 1 cycle after cmd.
- Write 8'h87 then 8'h5A (EIR_ADV_TMR0) -> regs_o[63:56]=8'h5A, wr_strobe_o pulse, wr_addr_o=7, tx 8'hAA; then read 8'h07 -> 8'h5A.
- Read 8'h30 (index 48) -> tx 8'hEE; then read 8'h28 -> tx 8'h01; read 8'h28 again -> tx 8'h00.
- Write cmd 8'h81 with no data for TIMEOUT_CYCLES (set to 16) -> no tx, FSM IDLE, ERROR=8'h02; data byte on cycle 15 instead -> write completes, ACK.
- tx_ready_i held 0 for 20 cycles after a read -> tx_data_o stable; extra rx byte meanwhile -> dropped, ERROR bit3 set.
- Assert rst_n low during WAIT_DATA -> all outputs reset values, bank back to defaults, no ACK after release.
